// File: rtl/softmax_reduce.sv
// softmax_reduce
// Pops VEC_LEN signed elements from the softmax input FIFO after a start
// pulse, tracks the vector maximum and sum, and offers both downstream on a
// valid/ready handshake.
//
// Optional feature macro: SOFTMAX_REDUCE_SAT_EN
//   defined   -> every accumulate saturates to the signed SW-bit range
//   undefined -> the sum wraps modulo 2^SW
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   start       begin a vector (only honoured in IDLE)
//   busy        high while fetching or holding a result
//   fifo_rd_en  combinational FIFO read request
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO registered data_out (valid the cycle after a read)
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   out_max     signed vector maximum
//   out_sum     signed vector sum
//
// state | meaning
// IDLE  | waiting for start; counters and first-element flag cleared
// FETCH | issuing reads and capturing returned elements
// DONE  | result presented until out_ready
module softmax_reduce #(
    parameter int DW      = 16,
    parameter int VEC_LEN = 8,
    parameter int SW      = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          fifo_rd_en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_max,
    output logic [SW-1:0] out_sum
);

    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] LEN  = CW'(VEC_LEN);
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] issued, received;
    logic          pending;
    logic          have_first;
    logic [DW-1:0] max_q;
    logic [SW-1:0] sum_q;
    logic [SW-1:0] data_ext;
    logic [SW-1:0] sum_acc;

    assign data_ext = SW'($signed(fifo_data));

`ifdef SOFTMAX_REDUCE_SAT_EN
    // One guard bit detects overflow; clamp toward the sign of the true result.
    logic [SW:0] sum_wide;
    assign sum_wide = {sum_q[SW-1], sum_q} + {data_ext[SW-1], data_ext};
    always_comb begin
        sum_acc = sum_wide[SW-1:0];
        if (sum_wide[SW] != sum_wide[SW-1]) begin
            sum_acc = sum_wide[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end
    end
`else
    assign sum_acc = sum_q + data_ext;
`endif

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                fifo_rd_en = !rst && (issued < LEN) && !fifo_empty;
                // Leave on the edge that captures the final element.
                if (pending && (received == LAST)) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issued     <= '0;
            received   <= '0;
            pending    <= 1'b0;
            have_first <= 1'b0;
            max_q      <= '0;
            sum_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    issued     <= '0;
                    received   <= '0;
                    pending    <= 1'b0;
                    have_first <= 1'b0;
                end
                FETCH: begin
                    if (fifo_rd_en) issued <= issued + 1'b1;
                    pending <= fifo_rd_en;
                    if (pending) begin
                        received   <= received + 1'b1;
                        have_first <= 1'b1;
                        if (!have_first) begin
                            max_q <= fifo_data;
                            sum_q <= data_ext;
                        end else begin
                            if ($signed(fifo_data) > $signed(max_q)) max_q <= fifo_data;
                            sum_q <= sum_acc;
                        end
                    end
                end
                default: begin
                    pending <= 1'b0;
                end
            endcase
        end
    end

    assign out_max = max_q;
    assign out_sum = sum_q;

endmodule

// File: doc/softmax_reduce.md
# softmax_reduce

Reduction stage that sits directly downstream of the softmax input FIFO. On a start pulse it pops exactly `VEC_LEN` signed fixed-point elements through the FIFO's read port (`rd_en` / `empty` / registered `data_out`). It computes the vector maximum and the running sum. It then presents both on a valid/ready output to the exponent/normalise stage.

## Interface
Parameters:
- `DW`, 16, element width; elements are two's-complement signed.
- `VEC_LEN`, 8, elements per vector; must be ≥1.
- `SW`, 20, sum accumulator/output width; must be ≥`DW`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a vector; sampled only in IDLE.
- `busy` out 1: high in FETCH and DONE.
- `fifo_rd_en` out 1: read request to the FIFO; combinational.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in DW: FIFO `data_out`; valid the cycle after an accepted read.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_max` out DW: signed maximum of the vector.
- `out_sum` out SW: signed sum of the vector.

## Operation
- States:
  - IDLE: `start` → FETCH. Clears `issued`, `received` and the first-element flag.
  - FETCH: when `received == VEC_LEN` → DONE.
  - DONE: `out_valid && out_ready` → IDLE.
- `fifo_rd_en = (state==FETCH) && (issued < VEC_LEN) && !fifo_empty`. It is never high in IDLE, in DONE, or during `rst`.
- Accepted read: the cycle `fifo_rd_en` is high; `issued` increments.
- A registered flag `pending` is set the cycle after each accepted read. With `pending` set, `fifo_data` is captured and `received` increments.
- First captured element: `max = data`, `sum = sign-extend(data to SW)`.
- Later elements:
  - `max = (data > max) ? data : max`, signed compare; ties keep the old value.
  - `sum = sum + sign-extend(data)`.
- The last capture and the transition to DONE happen on the same edge; `out_max` and `out_sum` are registered and stable through DONE.
- `start` is ignored while `busy`. `start` in the same cycle as a DONE handshake is ignored; IDLE must be re-entered first.
- `fifo_empty` stalls issue only. An outstanding `pending` capture still completes.
- Counters are `$clog2(VEC_LEN+1)` bits wide and never wrap.

## Timing
- Reset values: `busy=0`, `fifo_rd_en=0`, `out_valid=0`, `out_max=0`, `out_sum=0`, state IDLE.
- Reset mid-vector: partial results are discarded. Elements already popped are lost; the upstream producer must be reset together with this block.
- FIFO read latency is 1 cycle, matching the FIFO's registered `data_out`.
- Latency with the FIFO never empty:
  - `start` sampled at edge E0.
  - Reads accepted at E1..E_VEC_LEN.
  - `out_valid` is high after E_(VEC_LEN+1), i.e. `VEC_LEN+1` cycles after the start edge.
- Each cycle of `fifo_empty` during issue adds exactly one cycle of latency.
- `out_valid` holds until `out_ready`. IDLE is entered on the handshake edge; the earliest next `start` is sampled the following edge.
- Throughput: one vector per `VEC_LEN+3` cycles at best.

## Configuration
- `SOFTMAX_REDUCE_SAT_EN`:
  - Defined: each accumulate saturates to [−2^(SW−1), 2^(SW−1)−1], and a saturated sum stays clamped for the remaining elements unless later additions bring it back in range.
  - Undefined: the sum wraps modulo 2^SW.
  - `out_max` is unaffected either way.

## Test plan
- Reset, then `start` with the FIFO pre-loaded with 8 elements 1..8 (DW=16, SW=20) → exactly 8 `fifo_rd_en` pulses, then `out_max=8` and `out_sum=36` with `out_valid` 9 cycles after the start edge.
- All-negative vector {−5,−3,−9,−3,−7,−1,−2,−4} → `out_max=−1` (0xFFFF), `out_sum=−34`.
- `fifo_empty` toggled high for 3 random cycles mid-vector → result unchanged, latency grows by 3, and `fifo_rd_en` is never high while `fifo_empty`.
- Hold `out_ready=0` for 10 cycles, with `start` pulsed repeatedly during DONE → outputs stable, no extra reads; after the handshake, IDLE, then a new `start` works.
- SW=16 with 8 × 0x7FFF elements:
  - With `SOFTMAX_REDUCE_SAT_EN` → `out_sum=0x7FFF`.
  - Without it → `out_sum=0xFFF8`.
- Assert `rst` after 4 accepted reads → the next cycle shows all outputs at reset values and `fifo_rd_en=0`; a fresh `start` with 8 new elements gives the correct result.
